// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch stage and its bus interface.
//   XLEN       datapath width
//   RESET_PC   default PC after reset
//   INST_NOP   value held in the IF/ID instruction register after reset
//   PC_STEP    sequential PC increment
//   fetch_entry_t  {pc, inst} pair stored in the instruction queue
package cpu_pkg;

    localparam int unsigned      XLEN     = 32;
    localparam logic [XLEN-1:0]  RESET_PC = 32'h0000_0064;
    localparam logic [XLEN-1:0]  INST_NOP = 32'h0000_0000;
    localparam logic [XLEN-1:0]  PC_STEP  = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and memory (slave).
//   imem_req     fetch request valid
//   imem_addr    fetch address
//   imem_ready   memory accepts the request when imem_req & imem_ready
//   imem_rvalid  in-order response valid
//   imem_rdata   instruction word
interface fetch_stage_if;
    import cpu_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with asynchronous active-high reset.
//   clk, reset   clock / async reset
//   push, wdata  write an entry (ignored when full unless a pop frees a slot)
//   pop          drop the head entry (ignored when empty)
//   clear        empty the FIFO; dominates push and pop
//   rdata        head entry (undefined content when empty)
//   full, empty, count  occupancy status
module fetch_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNTW  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNTW-1:0]  count
);

    localparam int unsigned PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTRW-1:0]  wptr_q, wptr_d;
    logic [PTRW-1:0]  rptr_q, rptr_d;
    logic [CNTW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    // Wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        return (p == PTRW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_q == CNTW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (clear) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) wptr_d = ptr_inc(wptr_q);
            if (do_pop)  rptr_d = ptr_inc(rptr_q);
            if (do_push && !do_pop) count_d = count_q + 1'b1;
            if (!do_push && do_pop) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem_q[wptr_q] <= wdata;
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, issues in-order fetches to a variable-latency instruction
// memory, buffers returned words and drives the IF/ID register.
//   clk, reset    clock / async active-high reset
//   imem          instruction-memory bus (master side)
//   dstall        decode stall, hold IF/ID
//   redirect      taken branch/jump: flush and restart at redirect_pc
//   redirect_pc   new fetch address
//   dinst, dpc, dvalid  IF/ID pipeline register
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = cpu_pkg::RESET_PC,
    parameter int unsigned     QDEPTH   = 2,
    parameter int unsigned     CNTW     = 2
) (
    input  logic              clk,
    input  logic              reset,
    fetch_stage_if.master     imem,
    input  logic              dstall,
    input  logic              redirect,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic [XLEN-1:0]   dinst,
    output logic [XLEN-1:0]   dpc,
    output logic              dvalid
);

    localparam logic [CNTW:0] QDEPTH_W = (CNTW + 1)'(QDEPTH);
    localparam logic [CNTW:0] CNT_MAX  = {1'b0, {CNTW{1'b1}}};

    logic [XLEN-1:0] pc_q, pc_d;
    logic [CNTW-1:0] outstanding_q, outstanding_d;
    logic [CNTW-1:0] drop_q, drop_d;
    logic [XLEN-1:0] dinst_q, dpc_q;
    logic            dvalid_q;

    logic            credit, accept;
    logic            resp_take, resp_drop, live;
    logic [CNTW:0]   inflight;

    // Instruction queue
    fetch_entry_t    q_wdata, q_head;
    logic            q_push, q_pop, q_full, q_empty;
    logic [CNTW-1:0] q_count;

    // Tag FIFO: addresses of accepted, not yet answered requests
    logic [XLEN-1:0] tag_head;
    logic            tag_full, tag_empty;
    logic [CNTW-1:0] tag_count;

    // Credit covers both in-flight and queued words so the queue can never overflow.
    assign inflight      = {1'b0, outstanding_q} + {1'b0, q_count};
    assign credit        = (inflight < QDEPTH_W);
    assign imem.imem_req  = !reset && !redirect && credit;
    assign imem.imem_addr = pc_q;
    assign accept        = imem.imem_req && imem.imem_ready;

    // A response either retires a stale (pre-redirect) fetch or a live one.
    assign resp_drop = imem.imem_rvalid && (drop_q != '0);
    assign resp_take = imem.imem_rvalid && (drop_q == '0);
    assign live      = resp_take && !redirect;

    // With the queue non-empty a live word must queue behind it to keep order.
    assign q_wdata = '{pc: tag_head, inst: imem.imem_rdata};
    assign q_push  = live && (dstall || !q_empty);
    assign q_pop   = !redirect && !dstall && !q_empty;

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (QDEPTH),
        .CNTW  (CNTW)
    ) u_inst_q (
        .clk   (clk),
        .reset (reset),
        .push  (q_push),
        .pop   (q_pop),
        .clear (redirect),
        .wdata (q_wdata),
        .rdata (q_head),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (QDEPTH),
        .CNTW  (CNTW)
    ) u_tag_q (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .pop   (resp_take),
        .clear (redirect),
        .wdata (pc_q),
        .rdata (tag_head),
        .full  (tag_full),
        .empty (tag_empty),
        .count (tag_count)
    );

    always_comb begin
        pc_d          = pc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        if (redirect) begin
            pc_d          = redirect_pc;
            outstanding_d = '0;
            // Every in-flight fetch becomes stale; a response arriving now retires one.
            drop_d        = drop_q + outstanding_q - CNTW'(imem.imem_rvalid);
        end else begin
            if (accept) pc_d = next_pc(pc_q);
            if (accept && !resp_take) outstanding_d = outstanding_q + 1'b1;
            if (!accept && resp_take) outstanding_d = outstanding_q - 1'b1;
            if (resp_drop)            drop_d        = drop_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    // IF/ID register: redirect beats stall; dinst/dpc keep stale contents on flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dinst_q  <= INST_NOP;
            dpc_q    <= '0;
            dvalid_q <= 1'b0;
        end else if (redirect) begin
            dvalid_q <= 1'b0;
        end else if (!dstall) begin
            if (!q_empty) begin
                dinst_q  <= q_head.inst;
                dpc_q    <= q_head.pc;
                dvalid_q <= 1'b1;
            end else if (live) begin
                dinst_q  <= imem.imem_rdata;
                dpc_q    <= tag_head;
                dvalid_q <= 1'b1;
            end else begin
                dvalid_q <= 1'b0;
            end
        end
    end

    assign dinst  = dinst_q;
    assign dpc    = dpc_q;
    assign dvalid = dvalid_q;

    // Invariant checks on counters and queues.
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(q_push && q_full && !q_pop))
                else $error("fetch_stage: response pushed into full queue");
            assert (!(accept && tag_full))
                else $error("fetch_stage: tag fifo overflow");
            assert (!(resp_take && tag_empty))
                else $error("fetch_stage: response without outstanding request");
            assert (tag_count == outstanding_q)
                else $error("fetch_stage: tag fifo out of step with outstanding count");
            assert (!(redirect && ({1'b0, drop_q} + {1'b0, outstanding_q} > CNT_MAX)))
                else $error("fetch_stage: drop counter wrap");
            assert (!(accept && !resp_take && ({1'b0, outstanding_q} == CNT_MAX)))
                else $error("fetch_stage: outstanding counter wrap");
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        dstall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] dinst;
    logic [31:0] dpc;
    logic        dvalid;

    int checks   = 0;
    int failures = 0;
    int mem_lat  = 1;
    int cyc      = 0;

    fetch_stage_if imem_bus ();

    fetch_stage #(
        .RESET_PC (32'h0000_0064),
        .QDEPTH   (2),
        .CNTW     (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem        (imem_bus),
        .dstall      (dstall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .dinst       (dinst),
        .dpc         (dpc),
        .dvalid      (dvalid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // In-order memory: a request accepted at edge k is presented on rvalid from
    // just after edge k+mem_lat-1, so the DUT samples it at edge k+mem_lat.
    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;
    pend_t pend[$];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pend.delete();
            cyc = 0;
            imem_bus.imem_rvalid <= 1'b0;
            imem_bus.imem_rdata  <= '0;
        end else begin
            cyc = cyc + 1;
            if (imem_bus.imem_rvalid && pend.size() > 0) void'(pend.pop_front());
            if (imem_bus.imem_req && imem_bus.imem_ready)
                pend.push_back('{addr: imem_bus.imem_addr, due: cyc + mem_lat - 1});
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                imem_bus.imem_rvalid <= 1'b1;
                imem_bus.imem_rdata  <= inst_of(pend[0].addr);
            end else begin
                imem_bus.imem_rvalid <= 1'b0;
                imem_bus.imem_rdata  <= '0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        dstall      = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        imem_bus.imem_ready = 1'b0;
        mem_lat     = 1;
        step();
        step();
        check("rst_req",    {31'b0, imem_bus.imem_req}, 32'd0);
        check("rst_addr",   imem_bus.imem_addr, 32'h64);
        check("rst_dvalid", {31'b0, dvalid}, 32'd0);
        check("rst_dinst",  dinst, 32'd0);
        check("rst_dpc",    dpc, 32'd0);

        // 1: streaming with 1-cycle latency
        reset = 1'b0;
        imem_bus.imem_ready = 1'b1;
        #1;
        check("t1_req0",  {31'b0, imem_bus.imem_req}, 32'd1);
        check("t1_addr0", imem_bus.imem_addr, 32'h64);
        step();
        check("t1_addr1",   imem_bus.imem_addr, 32'h68);
        check("t1_dvalid1", {31'b0, dvalid}, 32'd0);
        step();
        check("t1_dvalid2", {31'b0, dvalid}, 32'd1);
        check("t1_dpc2",    dpc, 32'h64);
        check("t1_dinst2",  dinst, inst_of(32'h64));
        check("t1_addr2",   imem_bus.imem_addr, 32'h6C);
        step();
        check("t1_dpc3", dpc, 32'h68);
        step();
        check("t1_dpc4", dpc, 32'h6C);

        // 2: decode stall for three cycles
        dstall = 1'b1;
        step();
        check("t2_dpc_s1",  dpc, 32'h6C);
        check("t2_req_s1",  {31'b0, imem_bus.imem_req}, 32'd0);
        check("t2_addr_s1", imem_bus.imem_addr, 32'h78);
        step();
        check("t2_dpc_s2", dpc, 32'h6C);
        check("t2_req_s2", {31'b0, imem_bus.imem_req}, 32'd0);
        step();
        check("t2_dpc_s3",    dpc, 32'h6C);
        check("t2_dinst_s3",  dinst, inst_of(32'h6C));
        check("t2_dvalid_s3", {31'b0, dvalid}, 32'd1);
        check("t2_req_s3",    {31'b0, imem_bus.imem_req}, 32'd0);
        dstall = 1'b0;
        step();
        check("t2_dpc_r1", dpc, 32'h70);
        check("t2_req_r1", {31'b0, imem_bus.imem_req}, 32'd1);
        step();
        check("t2_dpc_r2", dpc, 32'h74);
        step();
        check("t2_dpc_r3",   dpc, 32'h78);
        check("t2_dinst_r3", dinst, inst_of(32'h78));

        // 3: redirect with two fetches outstanding, latency 3
        mem_lat = 3;
        step();
        check("t3_dpc_a", dpc, 32'h7C);
        step();
        check("t3_dvalid_b", {31'b0, dvalid}, 32'd0);
        check("t3_req_b",    {31'b0, imem_bus.imem_req}, 32'd0);
        check("t3_addr_b",   imem_bus.imem_addr, 32'h88);
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        step();
        redirect = 1'b0;
        #1;
        check("t3_dvalid_r", {31'b0, dvalid}, 32'd0);
        check("t3_req_r",    {31'b0, imem_bus.imem_req}, 32'd1);
        check("t3_addr_r",   imem_bus.imem_addr, 32'h200);
        step();
        check("t3_dvalid_d1", {31'b0, dvalid}, 32'd0);
        check("t3_addr_d1",   imem_bus.imem_addr, 32'h204);
        step();
        check("t3_dvalid_d2", {31'b0, dvalid}, 32'd0);
        check("t3_req_d2",    {31'b0, imem_bus.imem_req}, 32'd0);
        step();
        check("t3_dvalid_d3", {31'b0, dvalid}, 32'd0);
        step();
        check("t3_dvalid_n", {31'b0, dvalid}, 32'd1);
        check("t3_dpc_n",    dpc, 32'h200);
        check("t3_dinst_n",  dinst, inst_of(32'h200));
        step();
        check("t3_dpc_n2", dpc, 32'h204);

        // 4: redirect coinciding with a response while decode is stalled
        dstall = 1'b1;
        step();
        check("t4_dvalid_h", {31'b0, dvalid}, 32'd1);
        check("t4_dpc_h",    dpc, 32'h204);
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        #1;
        check("t4_req_redir", {31'b0, imem_bus.imem_req}, 32'd0);
        step();
        redirect = 1'b0;
        dstall   = 1'b0;
        #1;
        check("t4_dvalid_r", {31'b0, dvalid}, 32'd0);
        check("t4_dpc_keep", dpc, 32'h204);
        check("t4_req_r",    {31'b0, imem_bus.imem_req}, 32'd1);
        check("t4_addr_r",   imem_bus.imem_addr, 32'h200);
        step();
        check("t4_dvalid_d1", {31'b0, dvalid}, 32'd0);
        check("t4_addr_d1",   imem_bus.imem_addr, 32'h204);
        step();
        check("t4_dvalid_d2", {31'b0, dvalid}, 32'd0);
        step();
        check("t4_dvalid_d3", {31'b0, dvalid}, 32'd0);
        step();
        check("t4_dvalid_n", {31'b0, dvalid}, 32'd1);
        check("t4_dpc_n",    dpc, 32'h200);

        // 5: memory not ready for five cycles
        imem_bus.imem_ready = 1'b0;
        step();
        check("t5_dpc_0",    dpc, 32'h204);
        check("t5_dvalid_0", {31'b0, dvalid}, 32'd1);
        check("t5_addr_0",   imem_bus.imem_addr, 32'h208);
        for (int i = 1; i < 5; i++) begin
            step();
            check($sformatf("t5_addr_%0d", i),   imem_bus.imem_addr, 32'h208);
            check($sformatf("t5_req_%0d", i),    {31'b0, imem_bus.imem_req}, 32'd1);
            check($sformatf("t5_dvalid_%0d", i), {31'b0, dvalid}, 32'd0);
        end
        imem_bus.imem_ready = 1'b1;
        step();
        check("t5_addr_go", imem_bus.imem_addr, 32'h20C);
        step();
        check("t5_req_full", {31'b0, imem_bus.imem_req}, 32'd0);
        check("t5_addr_2",   imem_bus.imem_addr, 32'h210);

        // 6: asynchronous reset with two fetches outstanding
        #1;
        reset = 1'b1;
        #1;
        check("t6_dvalid", {31'b0, dvalid}, 32'd0);
        check("t6_dinst",  dinst, 32'd0);
        check("t6_dpc",    dpc, 32'd0);
        check("t6_req",    {31'b0, imem_bus.imem_req}, 32'd0);
        check("t6_addr",   imem_bus.imem_addr, 32'h64);
        step();
        step();
        mem_lat = 1;
        reset   = 1'b0;
        #1;
        check("t6_req_rel",  {31'b0, imem_bus.imem_req}, 32'd1);
        check("t6_addr_rel", imem_bus.imem_addr, 32'h64);
        step();
        check("t6_addr_nx", imem_bus.imem_addr, 32'h68);
        step();
        check("t6_dvalid_nx", {31'b0, dvalid}, 32'd1);
        check("t6_dpc_nx",    dpc, 32'h64);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
